// File: rtl/modexp_ctrl_if.sv
// Handshake bundle between modexp_ctrl and its Montgomery multiplier.
// The controller drives operands and start; the multiplier answers with result/done.
interface modexp_ctrl_if #(
  parameter int N = 1024
);
  logic         mm_start;
  logic [N-1:0] mm_a;
  logic [N-1:0] mm_b;
  logic [N-1:0] mm_m;
  logic [N-1:0] mm_result;
  logic         mm_done;

  modport master (
    output mm_start, mm_a, mm_b, mm_m,
    input  mm_result, mm_done
  );

  modport slave (
    input  mm_start, mm_a, mm_b, mm_m,
    output mm_result, mm_done
  );
endinterface

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing x^e mod M in the
// Montgomery domain with one shared external multiplier.
module modexp_ctrl #(
  parameter int N       = 1024,
  parameter int E_WIDTH = 1024,
  parameter int LEN_W   = 11
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N-1:0]       in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]   e_len,
  input  logic [N-1:0]       in_m,
  input  logic [N-1:0]       in_r,
  input  logic [N-1:0]       in_r2,
  output logic [N-1:0]       result,
  output logic               done,
  output logic               busy,
  modexp_ctrl_if.master      mm
);

  typedef enum logic [2:0] {
    S_IDLE, S_TOMONT, S_LOOP_SQ, S_LOOP_MUL, S_FROMMONT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_LOAD, PH_START, PH_WAIT
  } phase_t;

  state_t state, state_next;
  phase_t phase, phase_next;

  logic [N-1:0]       x_q, r_q, r2_q, m_q, xm_q, acc_q, result_q, a_q, b_q;
  logic [E_WIDTH-1:0] e_q, e_shift;
  logic [LEN_W-1:0]   len_q, i_q, i_dec;
  logic               done_q, busy_q;
  logic               accept, op_state, capture, e_bit;
  logic [N-1:0]       op_a, op_b;

  assign op_state = (state != S_IDLE) && (state != S_DONE);
  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign capture  = op_state && (phase == PH_WAIT) && mm.mm_done;
  assign i_dec    = i_q - LEN_W'(1);
  // Exponent bit i-1 is the one the square just consumed.
  assign e_shift  = e_q >> i_dec;
  assign e_bit    = e_shift[0];

  assign mm.mm_start = op_state && (phase == PH_START);
  assign mm.mm_a     = a_q;
  assign mm.mm_b     = b_q;
  assign mm.mm_m     = m_q;
  assign result      = result_q;
  assign done        = done_q;
  assign busy        = busy_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      phase <= PH_LOAD;
    end else begin
      state <= state_next;
      phase <= phase_next;
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase;
    op_a       = '0;
    op_b       = '0;
    case (state)
      S_TOMONT:   begin op_a = x_q;   op_b = r2_q; end
      S_LOOP_SQ:  begin op_a = acc_q; op_b = acc_q; end
      S_LOOP_MUL: begin op_a = acc_q; op_b = xm_q; end
      S_FROMMONT: begin op_a = acc_q; op_b = {{(N-1){1'b0}}, 1'b1}; end
      default:    ;
    endcase
    if (!op_state) begin
      if (accept) begin
        state_next = S_TOMONT;
        phase_next = PH_LOAD;
      end
    end else begin
      case (phase)
        PH_LOAD:  phase_next = PH_START;
        PH_START: phase_next = PH_WAIT;
        default: begin
          if (mm.mm_done) begin
            phase_next = PH_LOAD;
            case (state)
              S_TOMONT:   state_next = (len_q == '0) ? S_FROMMONT : S_LOOP_SQ;
              S_LOOP_SQ:  state_next = e_bit ? S_LOOP_MUL :
                                       ((i_dec == '0) ? S_FROMMONT : S_LOOP_SQ);
              S_LOOP_MUL: state_next = (i_q == '0) ? S_FROMMONT : S_LOOP_SQ;
              default:    state_next = S_DONE;
            endcase
          end
        end
      endcase
    end
  end

  // Operand latch, operand registers and per-state capture of the multiplier result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q      <= '0;
      e_q      <= '0;
      len_q    <= '0;
      m_q      <= '0;
      r_q      <= '0;
      r2_q     <= '0;
      xm_q     <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (accept) begin
        x_q    <= in_x;
        e_q    <= in_e;
        len_q  <= e_len;
        m_q    <= in_m;
        r_q    <= in_r;
        r2_q   <= in_r2;
        done_q <= 1'b0;
        busy_q <= 1'b1;
      end
      if (op_state && (phase == PH_LOAD)) begin
        a_q <= op_a;
        b_q <= op_b;
      end
      if (capture) begin
        case (state)
          S_TOMONT: begin
            xm_q  <= mm.mm_result;
            acc_q <= r_q;
            i_q   <= len_q;
          end
          S_LOOP_SQ: begin
            acc_q <= mm.mm_result;
            i_q   <= i_dec;
          end
          S_LOOP_MUL: acc_q <= mm.mm_result;
          S_FROMMONT: begin
            result_q <= mm.mm_result;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl with an 8-bit behavioural Montgomery multiplier
// answering five cycles after each start pulse.
module tb_modexp_ctrl;

  localparam int N = 8;
  localparam int E_WIDTH = 8;
  localparam int LEN_W = 4;

  logic               clk = 1'b0;
  logic               resetn;
  logic               start;
  logic [N-1:0]       in_x, in_m, in_r, in_r2;
  logic [E_WIDTH-1:0] in_e;
  logic [LEN_W-1:0]   e_len;
  logic [N-1:0]       result;
  logic               done, busy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  modexp_ctrl_if #(.N(N)) mm_if ();

  modexp_ctrl #(.N(N), .E_WIDTH(E_WIDTH), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_x   (in_x),
    .in_e   (in_e),
    .e_len  (e_len),
    .in_m   (in_m),
    .in_r   (in_r),
    .in_r2  (in_r2),
    .result (result),
    .done   (done),
    .busy   (busy),
    .mm     (mm_if.master)
  );

  always #5 clk = ~clk;

  // Bit-serial Montgomery product a*b*2^-8 mod m, fully reduced.
  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] m);
    logic [9:0] t;
    t = '0;
    for (int k = 0; k < 8; k++) begin
      if (a[k]) t = t + 10'(b);
      if (t[0]) t = t + 10'(m);
      t = t >> 1;
    end
    if (t >= 10'(m)) t = t - 10'(m);
    return t[7:0];
  endfunction

  logic [7:0] pa = '0;
  logic [7:0] pb = '0;
  int         mcnt = 0;

  always @(posedge clk) begin
    if (mm_if.mm_start) begin
      pa   <= mm_if.mm_a;
      pb   <= mm_if.mm_b;
      mcnt <= 5;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end

  assign mm_if.mm_done   = (mcnt == 1);
  assign mm_if.mm_result = mont(pa, pb, mm_if.mm_m);

  logic [7:0] pulse_cnt = '0;
  logic [7:0] base;
  logic [7:0] log_a [0:255];
  logic [7:0] log_b [0:255];
  logic [7:0] log_m [0:255];

  always @(negedge clk) begin
    if (mm_if.mm_start) begin
      log_a[pulse_cnt] = mm_if.mm_a;
      log_b[pulse_cnt] = mm_if.mm_b;
      log_m[pulse_cnt] = mm_if.mm_m;
      pulse_cnt = pulse_cnt + 8'd1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Launch one exponentiation, scramble the inputs afterwards, and wait for done.
  task automatic apply_stimulus(input logic [7:0] x, input logic [7:0] e,
                                input logic [3:0] len, input logic [7:0] m,
                                input logic [7:0] r, input logic [7:0] r2,
                                input int mid_start, output int cycles,
                                output bit busy_gap);
    in_x = x; in_e = e; e_len = len; in_m = m; in_r = r; in_r2 = r2;
    base = pulse_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_x = ~x; in_e = ~e; e_len = ~len; in_m = ~m; in_r = ~r; in_r2 = ~r2;
    cycles = 0;
    busy_gap = 1'b0;
    while (!done && cycles < 2000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (!done && !busy) busy_gap = 1'b1;
      start = (mid_start != 0) && (cycles == mid_start);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  cycles;
    bit  gap;
    logic [7:0] exp_a [0:6];
    logic [7:0] exp_b [0:6];
    exp_a = '{8'd2, 8'd9, 8'd9, 8'd5, 8'd10, 8'd1, 8'd2};
    exp_b = '{8'd3, 8'd9, 8'd5, 8'd5, 8'd10, 8'd5, 8'd1};

    resetn = 1'b0; start = 1'b0;
    in_x = '0; in_e = '0; e_len = '0; in_m = '0; in_r = '0; in_r2 = '0;
    #1;
    check_output("rst_done",   32'(done), 32'd0);
    check_output("rst_busy",   32'(busy), 32'd0);
    check_output("rst_result", 32'(result), 32'd0);
    check_output("rst_mm_m",   32'(mm_if.mm_m), 32'd0);
    check_output("rst_start",  32'(mm_if.mm_start), 32'd0);
    #21;
    resetn = 1'b1;

    $display("[TB] case 1: 2^5 mod 13");
    apply_stimulus(8'd2, 8'd5, 4'd3, 8'd13, 8'd9, 8'd3, 0, cycles, gap);
    check_output("c1_result", 32'(result), 32'd6);
    check_output("c1_pulses", 32'(pulse_cnt - base), 32'd7);
    check_output("c1_cycles", 32'(cycles), 32'd49);
    check_output("c1_busy",   32'(busy), 32'd0);
    for (int k = 0; k < 7; k++) begin
      check_output($sformatf("c1_op%0d_a", k), 32'(log_a[base + 8'(k)]), 32'(exp_a[k]));
      check_output($sformatf("c1_op%0d_b", k), 32'(log_b[base + 8'(k)]), 32'(exp_b[k]));
    end
    check_output("c1_mm_m", 32'(log_m[base + 8'd3]), 32'd13);
    repeat (10) @(posedge clk);
    #1;
    check_output("c1_done_hold",   32'(done), 32'd1);
    check_output("c1_result_hold", 32'(result), 32'd6);

    $display("[TB] case 2: e_len = 0");
    apply_stimulus(8'd7, 8'hA5, 4'd0, 8'd13, 8'd9, 8'd3, 0, cycles, gap);
    check_output("c2_result", 32'(result), 32'd1);
    check_output("c2_pulses", 32'(pulse_cnt - base), 32'd2);
    check_output("c2_cycles", 32'(cycles), 32'd14);

    $display("[TB] case 3: 3^255 mod 13");
    apply_stimulus(8'd3, 8'hFF, 4'd8, 8'd13, 8'd9, 8'd3, 0, cycles, gap);
    check_output("c3_result",   32'(result), 32'd1);
    check_output("c3_pulses",   32'(pulse_cnt - base), 32'd18);
    check_output("c3_cycles",   32'(cycles), 32'd126);
    check_output("c3_busy_gap", 32'(gap), 32'd0);

    $display("[TB] case 4: start while busy");
    apply_stimulus(8'd2, 8'd5, 4'd3, 8'd13, 8'd9, 8'd3, 20, cycles, gap);
    check_output("c4_result", 32'(result), 32'd6);
    check_output("c4_pulses", 32'(pulse_cnt - base), 32'd7);
    check_output("c4_cycles", 32'(cycles), 32'd49);

    $display("[TB] case 5: reset during LOOP_SQ");
    in_x = 8'd2; in_e = 8'd5; e_len = 4'd3; in_m = 8'd13; in_r = 8'd9; in_r2 = 8'd3;
    base = pulse_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cycles = 0;
    while ((pulse_cnt - base) < 8'd2 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_output("c5_reached_sq", 32'(pulse_cnt - base), 32'd2);
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check_output("c5_rst_busy",   32'(busy), 32'd0);
    check_output("c5_rst_done",   32'(done), 32'd0);
    check_output("c5_rst_result", 32'(result), 32'd0);
    check_output("c5_rst_mm_a",   32'(mm_if.mm_a), 32'd0);
    check_output("c5_rst_mm_b",   32'(mm_if.mm_b), 32'd0);
    check_output("c5_rst_mm_m",   32'(mm_if.mm_m), 32'd0);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_output("c5_late_pulses", 32'(pulse_cnt - base), 32'd2);
    check_output("c5_late_busy",   32'(busy), 32'd0);
    check_output("c5_late_done",   32'(done), 32'd0);
    apply_stimulus(8'd2, 8'd5, 4'd3, 8'd13, 8'd9, 8'd3, 0, cycles, gap);
    check_output("c5_result", 32'(result), 32'd6);
    check_output("c5_pulses", 32'(pulse_cnt - base), 32'd7);
    check_output("c5_cycles", 32'(cycles), 32'd49);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
